rob_pair: RTL

- Two-wide, in-order completion tracker (small reorder buffer) that sits directly upstream of the commit stage.
- Allocates entries for dual-issued instructions in program order.
- Records out-of-order writeback completion from the two execution pipes.
- Presents the oldest two entries as valid_ex0/1 and complete_ex0/1 to the commit stage, then retires entries on commit0/commit1.

---
 rtl/rob_pair_if.sv | 48 ++++
 rtl/rob_pair.sv | 97 +++++++++
 2 files changed

// File: rtl/rob_pair_if.sv
// Port bundle for rob_pair: allocation, writeback, commit-window and status signals.
// master = issue/writeback/commit side, slave = the reorder buffer.
interface rob_pair_if #(
  parameter int DEPTH = 8,
  parameter int RD_W  = 5
);
  localparam int TAG_W = $clog2(DEPTH);

  // Handshakes: an allocation is taken on a rising edge where alloc0_valid_i and
  // alloc_ready_o are both high (alloc1 rides along only with alloc0); ready never
  // depends on valid. A retire happens on an edge where commitN_i is high and the
  // matching valid_exN_o/complete_exN_o are high, commit1 only together with commit0.
  logic              flush_i;
  logic              alloc0_valid_i;
  logic              alloc1_valid_i;
  logic [RD_W-1:0]   alloc0_rd_i;
  logic [RD_W-1:0]   alloc1_rd_i;
  logic              alloc_ready_o;
  logic [TAG_W-1:0]  alloc0_tag_o;
  logic [TAG_W-1:0]  alloc1_tag_o;
  logic              wb0_valid_i;
  logic [TAG_W-1:0]  wb0_tag_i;
  logic              wb1_valid_i;
  logic [TAG_W-1:0]  wb1_tag_i;
  logic              valid_ex0_o;
  logic              valid_ex1_o;
  logic              complete_ex0_o;
  logic              complete_ex1_o;
  logic [RD_W-1:0]   head_rd0_o;
  logic [RD_W-1:0]   head_rd1_o;
  logic              commit0_i;
  logic              commit1_i;
  logic [TAG_W:0]    count_o;

  modport master (
    output flush_i, alloc0_valid_i, alloc1_valid_i, alloc0_rd_i, alloc1_rd_i,
    output wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i, commit0_i, commit1_i,
    input  alloc_ready_o, alloc0_tag_o, alloc1_tag_o, valid_ex0_o, valid_ex1_o,
    input  complete_ex0_o, complete_ex1_o, head_rd0_o, head_rd1_o, count_o
  );

  modport slave (
    input  flush_i, alloc0_valid_i, alloc1_valid_i, alloc0_rd_i, alloc1_rd_i,
    input  wb0_valid_i, wb0_tag_i, wb1_valid_i, wb1_tag_i, commit0_i, commit1_i,
    output alloc_ready_o, alloc0_tag_o, alloc1_tag_o, valid_ex0_o, valid_ex1_o,
    output complete_ex0_o, complete_ex1_o, head_rd0_o, head_rd1_o, count_o
  );
endinterface

// File: rtl/rob_pair.sv
// Two-wide in-order completion tracker: allocates in pairs, records out-of-order
// writebacks, exposes the oldest two entries to commit and retires them in order.
module rob_pair #(
  parameter int DEPTH = 8,
  parameter int RD_W  = 5
) (
  input logic       clk_i,
  input logic       rst_i,
  rob_pair_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int PTR_W = TAG_W + 1;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] complete_q;
  logic [RD_W-1:0]  rd_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;

  logic [PTR_W-1:0] count;
  logic [TAG_W-1:0] hidx0, hidx1, tidx0, tidx1;
  logic             alloc_ready;
  logic             vex0, vex1, cex0, cex1;
  logic             acc0, acc1, ret0, ret1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count       = tail_q - head_q;
  assign hidx0       = head_q[TAG_W-1:0];
  assign hidx1       = hidx0 + TAG_W'(1);
  assign tidx0       = tail_q[TAG_W-1:0];
  assign tidx1       = tidx0 + TAG_W'(1);
  assign alloc_ready = (count <= PTR_W'(DEPTH - 2));

  assign vex0 = valid_q[hidx0];
  assign vex1 = valid_q[hidx1];
  assign cex0 = complete_q[hidx0];
  assign cex1 = complete_q[hidx1];

  assign acc0 = bus.alloc0_valid_i && alloc_ready;
  assign acc1 = acc0 && bus.alloc1_valid_i;
  // Commit sees only the registered complete bits; a same-cycle writeback waits a cycle.
  assign ret0 = bus.commit0_i && vex0 && cex0;
  assign ret1 = bus.commit1_i && ret0 && vex1 && cex1;

  assign bus.alloc_ready_o  = alloc_ready;
  assign bus.alloc0_tag_o   = tidx0;
  assign bus.alloc1_tag_o   = tidx1;
  assign bus.valid_ex0_o    = vex0;
  assign bus.valid_ex1_o    = vex1;
  assign bus.complete_ex0_o = cex0;
  assign bus.complete_ex1_o = cex1;
  assign bus.head_rd0_o     = vex0 ? rd_q[hidx0] : '0;
  assign bus.head_rd1_o     = vex1 ? rd_q[hidx1] : '0;
  assign bus.count_o        = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else if (bus.flush_i) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      if (bus.wb0_valid_i && valid_q[bus.wb0_tag_i]) complete_q[bus.wb0_tag_i] <= 1'b1;
      if (bus.wb1_valid_i && valid_q[bus.wb1_tag_i]) complete_q[bus.wb1_tag_i] <= 1'b1;
      if (ret0) begin
        valid_q[hidx0]    <= 1'b0;
        complete_q[hidx0] <= 1'b0;
      end
      if (ret1) begin
        valid_q[hidx1]    <= 1'b0;
        complete_q[hidx1] <= 1'b0;
      end
      // Tail slots are never the head slots: ready guarantees two free entries.
      if (acc0) begin
        valid_q[tidx0]    <= 1'b1;
        complete_q[tidx0] <= 1'b0;
      end
      if (acc1) begin
        valid_q[tidx1]    <= 1'b1;
        complete_q[tidx1] <= 1'b0;
      end
      head_q <= head_q + PTR_W'(ret0) + PTR_W'(ret1);
      tail_q <= tail_q + PTR_W'(acc0) + PTR_W'(acc1);
    end
  end

  // Destination registers are payload only; valid gating makes reset of them unnecessary.
  always_ff @(posedge clk_i) begin
    if (acc0) rd_q[tidx0] <= bus.alloc0_rd_i;
    if (acc1) rd_q[tidx1] <= bus.alloc1_rd_i;
  end
endmodule
